mmio_memory: RTL

MMIO_MEMORY -- requirements
Module: mmio_memory

---
 rtl/mmio_memory.sv | 71 +++++++
 1 files changed

// File: rtl/mmio_memory.sv
// mmio_memory: word RAM plus memory-mapped inport/outport slots with registered reads
module mmio_memory #(
  parameter int          WIDTH     = 32,
  parameter int          RAM_WORDS = 256,
  parameter int          NUM_PORTS = 2,
  parameter logic [31:0] IO_BASE   = 32'h0000FFF8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [WIDTH-1:0]               address,
  input  logic [WIDTH-1:0]               wr_data,
  input  logic [WIDTH/8-1:0]             byte_en,
  input  logic                           mem_write,
  input  logic                           mem_read,
  input  logic [NUM_PORTS*WIDTH-1:0]     in_data,
  input  logic [NUM_PORTS-1:0]           inport_en,
  output logic [WIDTH-1:0]               rd_data,
  output logic                           rd_valid,
  output logic [NUM_PORTS*WIDTH-1:0]     outport,
  output logic [NUM_PORTS-1:0]           inport_new,
  output logic                           addr_err
);
  localparam int               AW      = $clog2(RAM_WORDS);
  localparam int               NB      = WIDTH / 8;
  localparam logic [WIDTH-1:0] RAM_END = WIDTH'(RAM_WORDS * 4);
  localparam logic [WIDTH-1:0] IO_B    = WIDTH'(IO_BASE);
  logic [WIDTH-1:0]     ram    [RAM_WORDS];
  logic [WIDTH-1:0]     in_reg [NUM_PORTS];
  logic [NUM_PORTS-1:0] io_hit;
  logic [WIDTH-1:0]     rd_next;
  logic [AW-1:0]        idx;
  logic                 is_ram;
  logic                 mapped;
  assign idx    = address[AW+1:2];
  assign is_ram = address < RAM_END;
  assign mapped = is_ram | (|io_hit);
  always_comb begin
    io_hit  = '0;
    rd_next = is_ram ? ram[idx] : '0;
    for (int k = 0; k < NUM_PORTS; k++) begin
      io_hit[k] = address[WIDTH-1:2] == IO_B[WIDTH-1:2] + (WIDTH-2)'(k);
      rd_next   = io_hit[k] ? in_reg[k] : rd_next;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst && mem_write && is_ram)
      for (int b = 0; b < NB; b++)
        if (byte_en[b]) ram[idx][8*b +: 8] <= wr_data[8*b +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      addr_err   <= 1'b0;
      outport    <= '0;
      inport_new <= '0;
      for (int k = 0; k < NUM_PORTS; k++) in_reg[k] <= '0;
    end else begin
      rd_valid <= mem_read;
      addr_err <= (mem_read | mem_write) & ~mapped;
      if (mem_read) rd_data <= rd_next;
      for (int k = 0; k < NUM_PORTS; k++) begin
        inport_new[k] <= inport_en[k] | (inport_new[k] & ~(mem_read & io_hit[k]));
        if (inport_en[k]) in_reg[k] <= in_data[k*WIDTH +: WIDTH];
        if (mem_write && io_hit[k])
          for (int b = 0; b < NB; b++)
            if (byte_en[b]) outport[k*WIDTH + 8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end
endmodule
